// File: rtl/layer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// layer_seq_ctrl
//
// Purpose:
//   Sequences N_LAYERS processing layers one after another. A run is armed by
//   en, starts when the host finishes loading the input buffer (falling edge
//   of we), then enables each layer in turn. It waits for that layer's finish
//   flag and inserts a fixed idle gap before enabling the next layer. A
//   one-cycle done pulse marks completion of the last layer.
//
// Parameters:
//   N_LAYERS    - number of sequenced layers (1..8)
//   STALL_CYC   - idle gap in cycles between consecutive layers (1..65535)
//   TIMEOUT_CYC - maximum cycles one layer may run (timeout build only)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous reset, active low
//   en         in   run enable; dropping it aborts any run
//   we         in   host input-buffer write strobe; its falling edge starts a run
//   layer_fin  in   per-layer finish flags; only the active layer's bit is used
//   layer_en   out  one-hot registered enable to the active layer
//   cur_layer  out  index of the active or last-run layer
//   busy       out  high while receiving, running or in a gap
//   done       out  one-cycle pulse after the last layer's gap
//   err        out  sticky timeout flag
//
// Build option:
//   LAYER_SEQ_TIMEOUT_EN - when defined, a layer that runs TIMEOUT_CYC cycles
//   without finishing moves the sequencer to ERR. When undefined, RUN waits
//   indefinitely and err is tied low.
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no run; waiting for en
// RECV  | armed; waiting for the falling edge of we
// RUN   | layer idx enabled; waiting for layer_fin[idx]
// GAP   | idle gap of STALL_CYC cycles between layers
// DONE  | single-cycle completion pulse
// ERR   | layer timed out; held until en drops (timeout build only)

module layer_seq_ctrl #(
  parameter int unsigned N_LAYERS    = 5,
  parameter int unsigned STALL_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                we,
  input  logic [N_LAYERS-1:0] layer_fin,
  output logic [N_LAYERS-1:0] layer_en,
  output logic [2:0]          cur_layer,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RECV = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam logic [2:0] ERR  = 3'd5;
`endif

  localparam logic [2:0]  LAST_IDX  = 3'(N_LAYERS - 1);
  localparam logic [15:0] STALL_END = 16'(STALL_CYC - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic [15:0] stall_cnt;
  logic        we_q;
  logic        we_fall;
  logic [7:0]  fin_pad;
  logic        fin_cur;
  logic [7:0]  onehot_nxt;

  assign we_fall    = we_q & ~we;
  // Zero-extend to 8 bits so idx can address any bit for every legal N_LAYERS.
  assign fin_pad    = 8'(layer_fin);
  assign fin_cur    = fin_pad[idx];
  assign onehot_nxt = 8'd1 << idx_nxt;

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic [31:0] run_cnt;
  logic        run_tmo;

  assign run_tmo = (run_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYC;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        idx_nxt = 3'd0;
        if (en) state_nxt = RECV;
      end
      RECV: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (we_fall) begin
          state_nxt = RUN;
          idx_nxt   = 3'd0;
        end
      end
      RUN: begin
        // Abort wins over a finish flag arriving in the same cycle.
        if (!en) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
        end else if (fin_cur) begin
          state_nxt = GAP;
        end
`ifdef LAYER_SEQ_TIMEOUT_EN
        else if (run_tmo) begin
          state_nxt = ERR;
        end
`endif
      end
      GAP: begin
        if (!en) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
        end else if (stall_cnt == STALL_END) begin
          if (idx < LAST_IDX) begin
            state_nxt = RUN;
            idx_nxt   = idx + 3'd1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
`ifdef LAYER_SEQ_TIMEOUT_EN
      ERR: begin
        if (!en) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  // layer_en and cur_layer are derived from the next state so the enable is
  // already valid in the first RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      layer_en  <= '0;
      cur_layer <= 3'd0;
      stall_cnt <= 16'd0;
      we_q      <= 1'b0;
    end else begin
      we_q      <= we;
      state     <= state_nxt;
      idx       <= idx_nxt;
      layer_en  <= (state_nxt == RUN) ? onehot_nxt[N_LAYERS-1:0] : '0;
      if (state_nxt == RUN) cur_layer <= idx_nxt;
      stall_cnt <= (state == GAP && state_nxt == GAP) ? stall_cnt + 16'd1 : 16'd0;
    end
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  // Cleared whenever RUN is entered or left; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= 32'd0;
    end else if (state == RUN && state_nxt == RUN) begin
      if (run_cnt != 32'hFFFF_FFFF) run_cnt <= run_cnt + 32'd1;
    end else begin
      run_cnt <= 32'd0;
    end
  end

  assign err = (state == ERR);
`else
  assign err = 1'b0;
`endif

  assign busy = (state == RECV) || (state == RUN) || (state == GAP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_layer_seq_ctrl.sv
module tb_layer_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       we;
  logic [4:0] layer_fin;
  logic [4:0] layer_en;
  logic [2:0] cur_layer;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  layer_seq_ctrl #(
    .N_LAYERS   (5),
    .STALL_CYC  (4),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .we       (we),
    .layer_fin(layer_fin),
    .layer_en (layer_en),
    .cur_layer(cur_layer),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Arm, hold we high 10 cycles, drop it; layer 0 must be enabled at once.
  task automatic start_run();
    en = 1'b1;
    we = 1'b1;
    tick(1);
    chk("recv_busy", 32'(busy), 32'd1);
    chk("recv_layer_en", 32'(layer_en), 32'd0);
    tick(9);
    we = 1'b0;
    tick(1);
    chk("start_layer_en", 32'(layer_en), 32'd1);
    chk("start_cur_layer", 32'(cur_layer), 32'd0);
  endtask

  // Called one step after layer i's enable rose; finish after 20 cycles.
  task automatic layer_phase(input int i);
    for (int k = 0; k < 19; k++) begin
      chk("run_layer_en", 32'(layer_en), 32'(1 << i));
      chk("run_done", 32'(done), 32'd0);
      tick(1);
    end
    chk("run_last_layer_en", 32'(layer_en), 32'(1 << i));
    chk("run_cur_layer", 32'(cur_layer), 32'(i));
    layer_fin = 5'(1 << i);
    tick(1);
    layer_fin = 5'b0;
    chk("gap_entry_layer_en", 32'(layer_en), 32'd0);
    chk("gap_entry_busy", 32'(busy), 32'd1);
  endtask

  // Remaining gap cycles after GAP entry, then the next layer or done.
  task automatic gap_phase(input int i);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("gap_layer_en", 32'(layer_en), 32'd0);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_done", 32'(done), 32'd0);
    end
    tick(1);
    if (i < 4) begin
      chk("next_layer_en", 32'(layer_en), 32'(1 << (i + 1)));
      chk("next_cur_layer", 32'(cur_layer), 32'(i + 1));
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_layer_en", 32'(layer_en), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_cur_layer", 32'(cur_layer), 32'd4);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    we        = 1'b0;
    layer_fin = 5'b0;
    #1;
    chk("rst_layer_en", 32'(layer_en), 32'd0);
    chk("rst_cur_layer", 32'(cur_layer), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // we falling edge while idle must not start anything
    we = 1'b1;
    tick(2);
    we = 1'b0;
    tick(2);
    chk("idle_we_busy", 32'(busy), 32'd0);
    chk("idle_we_layer_en", 32'(layer_en), 32'd0);

    // Full run through all five layers
    start_run();
    for (int i = 0; i < 5; i++) begin
      layer_phase(i);
      gap_phase(i);
    end
    en = 1'b0;
    tick(1);
    chk("post_done_pulse", 32'(done), 32'd0);
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_cur_layer", 32'(cur_layer), 32'd4);
    tick(2);
    chk("post_done_idle", 32'(busy), 32'd0);

    // Abort during the gap after layer 2
    start_run();
    for (int i = 0; i < 3; i++) begin
      layer_phase(i);
      if (i < 2) gap_phase(i);
    end
    tick(1);
    en = 1'b0;
    tick(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_layer_en", 32'(layer_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("abort_hold_layer_en", 32'(layer_en), 32'd0);
      chk("abort_hold_done", 32'(done), 32'd0);
    end

    // Restart begins at layer 0; a foreign finish bit is ignored
    start_run();
    layer_fin = 5'b00100;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("wrong_fin_layer_en", 32'(layer_en), 32'd1);
      chk("wrong_fin_busy", 32'(busy), 32'd1);
    end
    layer_fin = 5'b00001;
    tick(1);
    layer_fin = 5'b0;
    chk("right_fin_layer_en", 32'(layer_en), 32'd0);
    chk("right_fin_busy", 32'(busy), 32'd1);
    gap_phase(0);

    // en drop and finish in the same cycle: abort wins, no gap
    en        = 1'b0;
    layer_fin = 5'b00010;
    tick(1);
    layer_fin = 5'b0;
    chk("simul_busy", 32'(busy), 32'd0);
    chk("simul_layer_en", 32'(layer_en), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("simul_hold_busy", 32'(busy), 32'd0);
      chk("simul_hold_done", 32'(done), 32'd0);
    end

    // Layer 1 never finishes
    start_run();
    layer_phase(0);
    gap_phase(0);
`ifdef LAYER_SEQ_TIMEOUT_EN
    tick(99);
    chk("tmo_pre_layer_en", 32'(layer_en), 32'd2);
    chk("tmo_pre_err", 32'(err), 32'd0);
    tick(1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_layer_en", 32'(layer_en), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    tick(3);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    en = 1'b0;
    tick(1);
    chk("tmo_err_clear", 32'(err), 32'd0);
    chk("tmo_clear_busy", 32'(busy), 32'd0);
`else
    tick(150);
    chk("wait_layer_en", 32'(layer_en), 32'd2);
    chk("wait_err", 32'(err), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick(1);
    chk("wait_abort_busy", 32'(busy), 32'd0);
`endif
    tick(2);

    // Reset pulse during layer 3
    start_run();
    for (int i = 0; i < 3; i++) begin
      layer_phase(i);
      gap_phase(i);
    end
    tick(5);
    chk("pre_rst_layer_en", 32'(layer_en), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_layer_en", 32'(layer_en), 32'd0);
    chk("mid_rst_cur_layer", 32'(cur_layer), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    tick(1);
    rst_n = 1'b1;
    // en is still high: the block re-arms but must wait for a new we edge
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("post_rst_layer_en", 32'(layer_en), 32'd0);
    end
    chk("post_rst_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick(2);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
